// File: rtl/adc_scan_arbiter.sv
// Round-robin sharing of one ADC0809-style converter among NREQ requesters.
// Optional macro ADC_PRIO_EN: requester 0 gets fixed top priority over the round-robin ring.
module adc_scan_arbiter #(
  parameter int NREQ         = 4,
  parameter int CLK_DIV      = 26,
  parameter int ALE_CYC      = 2,
  parameter int START_CYC    = 8,
  parameter int EOC_TIMEOUT  = 100,
  parameter int CONV_TIMEOUT = 4000,
  parameter int OE_CYC       = 10,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_ch,
  input  logic              eoc,
  input  logic [7:0]        result,
  output logic              adc_clk,
  output logic [2:0]        addr,
  output logic              ale,
  output logic              start,
  output logic              out_en,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [7:0]        data,
  output logic              timeout,
  output logic              busy
);

  localparam int M1      = (ALE_CYC > START_CYC) ? ALE_CYC : START_CYC;
  localparam int M2      = (M1 > EOC_TIMEOUT) ? M1 : EOC_TIMEOUT;
  localparam int M3      = (M2 > CONV_TIMEOUT) ? M2 : CONV_TIMEOUT;
  localparam int CNT_MAX = (M3 > OE_CYC) ? M3 : OE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;

  localparam logic [CW-1:0] ALE_LAST   = CW'(ALE_CYC - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] EOC_LAST   = CW'(EOC_TIMEOUT - 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_TIMEOUT - 1);
  localparam logic [CW-1:0] OE_LAST    = CW'(OE_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARB     = 4'd1;
  localparam logic [3:0] S_SETUP   = 4'd2;
  localparam logic [3:0] S_ALE     = 4'd3;
  localparam logic [3:0] S_START   = 4'd4;
  localparam logic [3:0] S_WAIT_LO = 4'd5;
  localparam logic [3:0] S_WAIT_HI = 4'd6;
  localparam logic [3:0] S_OE      = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            ale_q, start_q, oe_q, done_q, timeout_q, busy_q;
  logic [IDW-1:0]  done_id_q;
  logic [DW-1:0]   div_q;
  logic            adc_clk_q;
  logic            timeout_d;

  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic [2:0]      ch_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ch
    assign ch_arr[gi] = req_ch[3*gi +: 3];
  end

  // Descending scan: the last hit written is the nearest requester after last_q.
  always_comb begin
    int             idx;
    logic [IDW-1:0] sel;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    sel     = '0;
`ifdef ADC_PRIO_EN
    if (req[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int k = NREQ - 1; k >= 1; k--) begin
        idx = ((int'(last_q) + k - 1) % (NREQ - 1)) + 1;
        sel = IDW'(idx);
        if (req[sel]) begin
          win_vld = 1'b1;
          win_id  = sel;
        end
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NREQ;
      sel = IDW'(idx);
      if (req[sel]) begin
        win_vld = 1'b1;
        win_id  = sel;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    id_d    = id_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE:    if (|req) state_d = S_ARB;
      S_ARB: begin
        if (win_vld) begin
          state_d        = S_SETUP;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          addr_d         = ch_arr[win_id];
          id_d           = win_id;
`ifdef ADC_PRIO_EN
          if (win_id != '0) last_d = win_id;
`else
          last_d         = win_id;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:   state_d = S_ALE;
      S_ALE:     if (cnt_q == ALE_LAST) state_d = S_START;
      S_START:   if (cnt_q == START_LAST) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!eoc) state_d = S_WAIT_HI;
        else if (cnt_q == EOC_LAST) state_d = S_DONE;
      end
      S_WAIT_HI: begin
        if (eoc) state_d = S_OE;
        else if (cnt_q == CONV_LAST) state_d = S_DONE;
      end
      S_OE: begin
        if (cnt_q == OE_LAST) begin
          data_d  = result;
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_d == S_DONE || state_d == S_IDLE) gnt_d = '0;
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    // DONE can only follow a wait state when that wait expired.
    timeout_d = (state_d == S_DONE) && (state_q == S_WAIT_LO || state_q == S_WAIT_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= IDW'(NREQ - 1);
      id_q      <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ale_q     <= 1'b0;
      start_q   <= 1'b0;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ale_q     <= (state_d == S_ALE);
      start_q   <= (state_d == S_START);
      oe_q      <= (state_d == S_OE);
      done_q    <= (state_d == S_DONE);
      done_id_q <= (state_d == S_DONE) ? id_q : '0;
      timeout_q <= timeout_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      adc_clk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q     <= '0;
      adc_clk_q <= ~adc_clk_q;
    end else begin
      div_q     <= div_q + 1'b1;
    end
  end

  assign adc_clk = adc_clk_q;
  assign addr    = addr_q;
  assign ale     = ale_q;
  assign start   = start_q;
  assign out_en  = oe_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign data    = data_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adc_scan_arbiter.sv
// Self-checking bench for adc_scan_arbiter: vector table, corner sequences and random traffic.
// Build with +define+ADC_PRIO_EN to exercise the fixed-priority variant.
module tb_adc_scan_arbiter;
  localparam int NREQ = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_ch;
  logic        eoc;
  logic [7:0]  result;
  logic        adc_clk, ale, start, out_en, done, timeout, busy;
  logic [2:0]  addr;
  logic [3:0]  gnt;
  logic [1:0]  done_id;
  logic [7:0]  data;

  adc_scan_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ch(req_ch), .eoc(eoc), .result(result),
    .adc_clk(adc_clk), .addr(addr), .ale(ale), .start(start), .out_en(out_en),
    .gnt(gnt), .done(done), .done_id(done_id), .data(data), .timeout(timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ADC behaviour knobs
  int         lo_delay = 10;
  int         hi_delay = 10;
  bit         never_drop = 1'b0;
  logic [7:0] res_val = 8'h00;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic [7:0] data;
    logic       to;
    logic [2:0] addr;
    int         ale_len, start_len, oe_len, f2d;
    bit         gnt_bad, addr_bad, gnt_at_done;
  } tx_t;

  tx_t txq[$];

  typedef struct {
    logic [3:0]  rq;
    logic [11:0] ch;
    int          lo, hi;
    bit          nd;
    logic [7:0]  res;
    int          id_rr, id_pr;
    logic [7:0]  exp_data;
    bit          exp_to;
    int          exp_f2d;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Converter model: eoc falls lo_delay cycles after start falls, rises hi_delay later.
  initial begin
    int phase, mc;
    bit prev_s;
    eoc = 1'b1; result = 8'h00; phase = 0; mc = 0; prev_s = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset || done) begin
        phase = 0; eoc = 1'b1;
      end else begin
        case (phase)
          0: if (prev_s && !start && !never_drop) begin mc = 0; phase = 1; end
          1: begin mc++; if (mc == lo_delay) begin eoc = 1'b0; mc = 0; phase = 2; end end
          2: begin mc++; if (mc == hi_delay) begin eoc = 1'b1; result = res_val; phase = 0; end end
          default: phase = 0;
        endcase
      end
      prev_s = start;
    end
  end

  // Pin monitor: summarises each transaction into one record pushed at done.
  initial begin
    tx_t cur;
    bit pa, ps, run, ale_seen;
    cur = '{default:0}; pa = 0; ps = 0; run = 0; ale_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        cur = '{default:0}; run = 0; ale_seen = 0;
      end else begin
        if (gnt != 4'b0) begin
          if (cur.gnt == 4'b0) cur.gnt = gnt;
          else if (gnt != cur.gnt) cur.gnt_bad = 1;
          if (!$onehot(gnt)) cur.gnt_bad = 1;
        end
        if (ale && !pa) begin cur.addr = addr; ale_seen = 1; end
        else if (ale_seen && addr != cur.addr) cur.addr_bad = 1;
        cur.ale_len   += int'(ale);
        cur.start_len += int'(start);
        cur.oe_len    += int'(out_en);
        if (ps && !start) begin run = 1; cur.f2d = 0; end
        else if (run) cur.f2d++;
        if (done) begin
          cur.id = done_id; cur.data = data; cur.to = timeout;
          cur.gnt_at_done = (gnt != 4'b0);
          txq.push_back(cur);
          cur = '{default:0}; run = 0; ale_seen = 0;
        end
      end
      pa = ale; ps = start;
    end
  end

  task automatic wait_done(output tx_t r);
    bit got;
    got = 0;
    r = '{default:0};
    for (int i = 0; i < 6000 && !got; i++) begin
      @(posedge clk); #2;
      if (txq.size() > 0) begin r = txq.pop_front(); got = 1; end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL done_wait: got no done expected done within 6000 cycles");
    end else begin
      $display("tx: gnt=%b id=%0d addr=%0d data=%02h timeout=%0b f2d=%0d",
               r.gnt, r.id, r.addr, r.data, r.to, r.f2d);
      @(posedge clk); #2;
      chk("busy_after_done", busy, 1'b0);
      chk("done_one_cycle", done, 1'b0);
    end
  endtask

  task automatic check_tx(input tx_t r, input int eid, input logic [2:0] eaddr,
                          input logic [7:0] edata, input bit eto, input string tag);
    logic [3:0] eg;
    eg = 4'b0001 << eid;
    chk({tag, ".gnt"}, r.gnt, eg);
    chk({tag, ".done_id"}, r.id, eid);
    chk({tag, ".addr"}, r.addr, eaddr);
    chk({tag, ".data"}, r.data, edata);
    chk({tag, ".timeout"}, r.to, eto);
    chk({tag, ".ale_len"}, r.ale_len, 2);
    chk({tag, ".start_len"}, r.start_len, 8);
    chk({tag, ".oe_len"}, r.oe_len, eto ? 0 : 10);
    chk({tag, ".gnt_stable"}, r.gnt_bad, 1'b0);
    chk({tag, ".addr_stable"}, r.addr_bad, 1'b0);
    chk({tag, ".gnt_at_done"}, r.gnt_at_done, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  function automatic int pick(input logic [3:0] rq, input int last);
    int c;
    c = last;
`ifdef ADC_PRIO_EN
    if (rq[0]) return 0;
    for (int n = 0; n < 3; n++) begin c = (c % 3) + 1; if (rq[c]) return c; end
`else
    for (int n = 0; n < 4; n++) begin c = (c + 1) % 4; if (rq[c]) return c; end
`endif
    return -1;
  endfunction

  function automatic logic [2:0] ch_of(input logic [11:0] chv, input int id);
    return chv[3*id +: 3];
  endfunction

  initial begin
    vec_t vt[8];
    tx_t  r;
    int   eid, mlast, exp_a[5], exp_b[4];
    logic [7:0] mdata;
    bit   ok, dseen;
    int   gfirst, r1, r2;
    logic [3:0] gval;
    logic pc;

    vt[0] = '{4'b0010, 12'o0050, 20, 200, 0, 8'hA7, 1, 1, 8'hA7, 0, 231};
    vt[1] = '{4'b1111, 12'o4321,  3,  50, 0, 8'h3C, 2, 0, 8'h3C, 0, 64};
    vt[2] = '{4'b1001, 12'o6017, 10,  30, 0, 8'h5A, 3, 0, 8'h5A, 0, 51};
    vt[3] = '{4'b1001, 12'o2004,  2,   2, 0, 8'h81, 0, 0, 8'h81, 0, 15};
    vt[4] = '{4'b0001, 12'o0003,  5,   5, 1, 8'h55, 0, 0, 8'h81, 1, 100};
    vt[5] = '{4'b0001, 12'o0006,  1,   1, 0, 8'hFF, 0, 0, 8'hFF, 0, 13};
    vt[6] = '{4'b0110, 12'o0520,  7,   9, 0, 8'h12, 1, 2, 8'h12, 0, 27};
    vt[7] = '{4'b1000, 12'o7000,  5, 5000, 0, 8'h99, 3, 3, 8'h12, 1, 4006};

    reset = 1'b1; req = 4'b0; req_ch = 12'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", {adc_clk, addr, ale, start, out_en, gnt, done, done_id, data, timeout, busy}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("idle_busy", busy, 1'b0);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      lo_delay = vt[v].lo; hi_delay = vt[v].hi; never_drop = vt[v].nd; res_val = vt[v].res;
`ifdef ADC_PRIO_EN
      eid = vt[v].id_pr;
`else
      eid = vt[v].id_rr;
`endif
      req = vt[v].rq; req_ch = vt[v].ch;
      wait_done(r);
      check_tx(r, eid, ch_of(vt[v].ch, eid), vt[v].exp_data, vt[v].exp_to, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d.f2d", v), r.f2d, vt[v].exp_f2d);
    end
    never_drop = 0;

    // Request dropped and channel changed mid-transaction
    lo_delay = 4; hi_delay = 20; res_val = 8'h6E;
    req = 4'b1000; req_ch = 12'o4000;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(posedge clk); #2; if (gnt != 4'b0) ok = 1; end
    chk("seqC.gnt_seen", ok, 1'b1);
    req = 4'b0000; req_ch = 12'o7777;
    wait_done(r);
    check_tx(r, 3, 3'd4, 8'h6E, 0, "seqC");

    // Reset during WAIT_HI, then adc_clk phase from the reset point
    lo_delay = 5; hi_delay = 200; res_val = 8'hC3;
    req = 4'b0100; req_ch = 12'o0300;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); #2; if (start) ok = 1; end
    chk("seqA.start_rise", ok, 1'b1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #2; if (!start) ok = 1; end
    chk("seqA.start_fall", ok, 1'b1);
    repeat (20) begin @(posedge clk); #2; end
    pulse_reset();
    chk("seqA.outputs_after_reset", {adc_clk, addr, ale, start, out_en, gnt, done, done_id, data, timeout, busy}, 32'h0);
    chk("seqA.no_done_record", txq.size(), 0);
    dseen = 0; gfirst = -1; r1 = -1; r2 = -1; gval = 4'b0; pc = adc_clk;
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk); #2;
      if (done) dseen = 1;
      if (gnt != 4'b0 && gfirst < 0) begin gfirst = k; gval = gnt; end
      if (adc_clk && !pc) begin
        if (r1 < 0) r1 = k;
        else if (r2 < 0) r2 = k;
      end
      pc = adc_clk;
    end
    chk("seqA.no_done", dseen, 1'b0);
    chk("seqA.regrant_delay", gfirst, 2);
    chk("seqA.regrant_gnt", gval, 4'b0100);
    chk("seqA.adc_clk_first_rise", r1, 27);
    chk("seqA.adc_clk_period", r2 - r1, 54);
    wait_done(r);
    check_tx(r, 2, 3'd3, 8'hC3, 0, "seqA");

    // Back-to-back with all requesters held, then requester 0 dropped
`ifdef ADC_PRIO_EN
    exp_a = '{0, 0, 0, 0, 0};
`else
    exp_a = '{0, 1, 2, 3, 0};
`endif
    exp_b = '{1, 2, 3, 1};
    pulse_reset();
    lo_delay = 2; hi_delay = 5;
    req = 4'b1111; req_ch = 12'o1234;
    for (int i = 0; i < 5; i++) begin
      res_val = 8'h10 + 8'(i);
      wait_done(r);
      check_tx(r, exp_a[i], ch_of(12'o1234, exp_a[i]), 8'h10 + 8'(i), 0, $sformatf("rrA%0d", i));
    end
    req = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      res_val = 8'h20 + 8'(i);
      wait_done(r);
      check_tx(r, exp_b[i], ch_of(12'o1234, exp_b[i]), 8'h20 + 8'(i), 0, $sformatf("rrB%0d", i));
    end

    // Random traffic against the arbitration model
    req = 4'b0;
    pulse_reset();
    mlast = NREQ - 1; mdata = 8'h00;
    for (int t = 0; t < 30; t++) begin
      logic [3:0]  rq;
      logic [11:0] chv;
      rq = 4'($urandom_range(1, 15));
      chv = 12'($urandom);
      lo_delay = $urandom_range(1, 40);
      hi_delay = $urandom_range(1, 150);
      never_drop = ($urandom_range(0, 7) == 0);
      res_val = 8'($urandom);
      eid = pick(rq, mlast);
`ifdef ADC_PRIO_EN
      if (eid != 0) mlast = eid;
`else
      mlast = eid;
`endif
      if (!never_drop) mdata = res_val;
      req = rq; req_ch = chv;
      wait_done(r);
      check_tx(r, eid, ch_of(chv, eid), mdata, never_drop, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
